// File: rtl/nvram_upload_reader.sv
// Upload-side responder for one ioctl index: reads two bytes from the 8-bit save RAM,
// packs them into one 16-bit ioctl word, stalls hps_io meanwhile and holds the game CPU.
module nvram_upload_reader #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned RAM_LAT = 1,
    parameter logic [7:0]  INDEX   = 8'd4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [26:0]       ioctl_addr,
    output logic [15:0]       ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              hold_cpu
);

    localparam int unsigned IOCTL_AW = 27;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned DIN_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        WT_LO,
        RD_HI,
        WT_HI,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_rd_q, ram_rd_d;
    logic                wait_q, wait_d;
    logic [DIN_W-1:0]    din_q, din_d;
    logic                hold_q, hold_d;
    logic [7:0]          lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                oor_q, oor_d;

    logic                sel_c;
    logic [IOCTL_AW-1:0] req_addr_c;
    logic                req_oor_c;
    logic                lat_last_c;

    // Request decode: word-aligned byte address and range check against the RAM size
    always_comb begin
        sel_c      = ioctl_upload && (ioctl_index == INDEX);
        req_addr_c = ioctl_addr & ~IOCTL_AW'(1);
        req_oor_c  = (req_addr_c >> ADDR_W) != '0;
        lat_last_c = (cnt_q == CNT_W'(RAM_LAT - 1));
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        ram_rd_d   = 1'b0;
        wait_d     = wait_q;
        din_d      = din_q;
        hold_d     = sel_c;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        oor_d      = oor_q;

        unique case (state_q)
            IDLE: begin
                if (ioctl_rd && sel_c) begin
                    wait_d = 1'b1;
                    if (req_oor_c) begin
                        oor_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        oor_d      = 1'b0;
                        ram_addr_d = req_addr_c[ADDR_W-1:0];
                        ram_rd_d   = 1'b1;
                        state_d    = RD_LO;
                    end
                end
            end
            RD_LO: begin
                cnt_d   = '0;
                state_d = WT_LO;
            end
            WT_LO: begin
                if (lat_last_c) begin
                    lo_d       = ram_q;
                    ram_addr_d = {ram_addr_q[ADDR_W-1:1], 1'b1};
                    ram_rd_d   = 1'b1;
                    state_d    = RD_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_HI: begin
                cnt_d   = '0;
                state_d = WT_HI;
            end
            WT_HI: begin
                if (lat_last_c) begin
                    din_d   = {ram_q, lo_q};
                    wait_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (oor_q) begin
                    din_d = 16'hFFFF;
                end
                wait_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                wait_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Upload deselected mid-read: drop everything, keep the last delivered word
        if ((state_q != IDLE) && !sel_c) begin
            state_d  = IDLE;
            wait_d   = 1'b0;
            ram_rd_d = 1'b0;
            din_d    = din_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            ram_rd_q   <= 1'b0;
            wait_q     <= 1'b0;
            din_q      <= '0;
            hold_q     <= 1'b0;
            lo_q       <= '0;
            cnt_q      <= '0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_rd_q   <= ram_rd_d;
            wait_q     <= wait_d;
            din_q      <= din_d;
            hold_q     <= hold_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            oor_q      <= oor_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;
    assign hold_cpu   = hold_q;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench: four responders with RAM_LAT=1..4 share one stimulus and one RAM image.
module tb_nvram_upload_reader;

    localparam int unsigned NI = 4;
    localparam int unsigned WIN = 16;

    logic        clk;
    logic        reset_n;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [26:0] ioctl_addr;

    logic [15:0] din_v  [NI];
    logic        wait_v [NI];
    logic [9:0]  addr_v [NI];
    logic        rd_v   [NI];
    logic [7:0]  q_v    [NI];
    logic        hold_v [NI];

    logic [7:0]  mem [1024];

    int n_chk  = 0;
    int n_pass = 0;

    int          fall     [NI];
    logic [31:0] mask     [NI];
    logic        w1       [NI];
    logic        hold2    [NI];
    logic        hold_end [NI];
    logic [15:0] dend     [NI];
    logic [31:0] rst_snap [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [7:0] pipe [4];
        nvram_upload_reader #(
            .ADDR_W (10),
            .RAM_LAT(g + 1),
            .INDEX  (8'd4)
        ) u_dut (
            .clk_sys     (clk),
            .reset_n     (reset_n),
            .ioctl_upload(ioctl_upload),
            .ioctl_index (ioctl_index),
            .ioctl_rd    (ioctl_rd),
            .ioctl_addr  (ioctl_addr),
            .ioctl_din   (din_v[g]),
            .ioctl_wait  (wait_v[g]),
            .ram_addr    (addr_v[g]),
            .ram_rd      (rd_v[g]),
            .ram_q       (q_v[g]),
            .hold_cpu    (hold_v[g])
        );
        // RAM model: data valid exactly g+1 cycles after the strobe, junk otherwise
        always @(posedge clk) begin
            pipe[0] <= rd_v[g] ? mem[addr_v[g]] : 8'hEE;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign q_v[g] = pipe[g];
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s L=%0d: got %h expected %h", nm, inst + 1, act, exp);
    endtask

    function automatic logic [15:0] word_at(input logic [26:0] a);
        logic [9:0] b;
        b = a[9:0] & 10'h3FE;
        return {mem[b | 10'd1], mem[b]};
    endfunction

    function automatic logic [31:0] exp_mask(input int inst);
        return (32'd1 << 1) | (32'd1 << (3 + inst));
    endfunction

    // Issue one read at a negedge and watch WIN cycles; cycle k sampled mid-cycle
    task automatic run_rd(input logic [26:0] addr, input logic [7:0] idx,
                          input int drop_k, input int rst_k, input bit xtra);
        ioctl_upload = 1'b1;
        ioctl_index  = idx;
        ioctl_addr   = addr;
        ioctl_rd     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ioctl_rd = 1'b0;
        for (int i = 0; i < NI; i++) begin
            fall[i] = 0;
            mask[i] = '0;
        end
        for (int k = 1; k <= WIN; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (k == 1) w1[i] = wait_v[i];
                if (k == 2) hold2[i] = hold_v[i];
                if (!wait_v[i] && fall[i] == 0) fall[i] = k;
                if (rd_v[i]) mask[i][k] = 1'b1;
            end
            if (k == drop_k) ioctl_upload = 1'b0;
            if (k == rst_k) begin
                reset_n = 1'b0;
                #1;
                for (int i = 0; i < NI; i++)
                    rst_snap[i] = {4'(0), din_v[i], wait_v[i], rd_v[i], addr_v[i]} | 32'(hold_v[i]);
            end
            ioctl_rd = xtra && (k == 2 || k == 3);
            if (xtra && k == 2) ioctl_addr = 27'h40;
            @(negedge clk);
        end
        for (int i = 0; i < NI; i++) begin
            dend[i]     = din_v[i];
            hold_end[i] = hold_v[i];
        end
        ioctl_rd = 1'b0;
    endtask

    typedef struct {
        logic [26:0] addr;
        logic [7:0]  idx;
        logic [15:0] din;
        bit          acc;
        bit          oor;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int errs [NI];
        int ef;
        logic [31:0] em;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 2));
        mem[10'h10] = 8'hA5;
        mem[10'h11] = 8'h3C;

        vecs[0] = '{27'h10,      8'd4, 16'h3CA5,          1'b1, 1'b0};
        vecs[1] = '{27'h11,      8'd4, 16'h3CA5,          1'b1, 1'b0};
        vecs[2] = '{27'h400,     8'd4, 16'hFFFF,          1'b1, 1'b1};
        vecs[3] = '{27'h20,      8'd3, 16'hFFFF,          1'b0, 1'b0};
        vecs[4] = '{27'h3FE,     8'd4, word_at(27'h3FE),  1'b1, 1'b0};
        vecs[5] = '{27'h7FFFFFE, 8'd4, 16'hFFFF,          1'b1, 1'b1};
        vecs[6] = '{27'h0,       8'd4, word_at(27'h0),    1'b1, 1'b0};

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk("reset_outputs", i, {din_v[i], wait_v[i], rd_v[i], hold_v[i], 3'd0, addr_v[i]}, '0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_rd(vecs[v].addr, vecs[v].idx, 0, 0, 1'b0);
            for (int i = 0; i < NI; i++) begin
                ef = !vecs[v].acc ? 1 : (vecs[v].oor ? 2 : 5 + 2 * i);
                em = (vecs[v].acc && !vecs[v].oor) ? exp_mask(i) : 32'd0;
                chk($sformatf("vec%0d_din", v), i, 32'(dend[i]), 32'(vecs[v].din));
                chk($sformatf("vec%0d_wait_fall", v), i, fall[i], ef);
                chk($sformatf("vec%0d_ram_rd_cycles", v), i, mask[i], em);
                chk($sformatf("vec%0d_wait_c1", v), i, 32'(w1[i]), 32'(vecs[v].acc));
                chk($sformatf("vec%0d_hold", v), i, 32'(hold2[i]), 32'(vecs[v].idx == 8'd4));
            end
        end

        // Read strobe in the same cycle the upload is selected
        ioctl_upload = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_idle", 0, 32'(hold_v[0]), 32'd0);
        run_rd(27'h10, 8'd4, 0, 0, 1'b0);
        for (int i = 0; i < NI; i++) begin
            chk("rise_din", i, 32'(dend[i]), 32'h3CA5);
            chk("rise_fall", i, fall[i], 5 + 2 * i);
        end

        // Upload dropped during cycle 2
        run_rd(27'h20, 8'd4, 2, 0, 1'b0);
        for (int i = 0; i < NI; i++) begin
            chk("drop_din_kept", i, 32'(dend[i]), 32'h3CA5);
            chk("drop_wait_fall", i, fall[i], 3);
            chk("drop_ram_rd", i, mask[i], 32'h2);
            chk("drop_hold", i, 32'(hold_end[i]), 32'd0);
        end

        // Extra strobes while busy
        run_rd(27'h30, 8'd4, 0, 0, 1'b1);
        for (int i = 0; i < NI; i++) begin
            chk("busy_rd_din", i, 32'(dend[i]), 32'(word_at(27'h30)));
            chk("busy_rd_fall", i, fall[i], 5 + 2 * i);
            chk("busy_rd_ram_rd", i, mask[i], exp_mask(i));
        end

        // Async reset mid-read, then a normal read
        run_rd(27'h20, 8'd4, 0, 2, 1'b0);
        for (int i = 0; i < NI; i++) chk("midread_reset", i, rst_snap[i], '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_rd(27'h0, 8'd4, 0, 0, 1'b0);
        for (int i = 0; i < NI; i++) begin
            chk("post_reset_din", i, 32'(dend[i]), 32'(word_at(27'h0)));
            chk("post_reset_fall", i, fall[i], 5 + 2 * i);
        end

        // Full-image sweep
        for (int i = 0; i < NI; i++) errs[i] = 0;
        for (int a = 0; a < 1024; a += 2) begin
            run_rd(27'(a), 8'd4, 0, 0, 1'b0);
            for (int i = 0; i < NI; i++)
                if (dend[i] !== word_at(27'(a)) || fall[i] != 5 + 2 * i) errs[i]++;
        end
        for (int i = 0; i < NI; i++) chk("sweep_bad_words", i, errs[i], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
